// File: rtl/rpd_pkg.sv
// Shared types and defaults for the RPD moving-average pipeline controller.
package rpd_pkg;
  localparam int CNT_WIDTH_DEF = 10;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FILL_SHORT = 2'd1,
    FILL_LONG  = 2'd2,
    RUN        = 2'd3
  } state_e;
endpackage

// File: rtl/rpd_pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
module sat_counter #(
  parameter int W = 10
) (
  input  logic         i_clk,
  input  logic         i_nrst,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr)                   cnt_d = '0;
    else if (i_en && cnt_q != '1) cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign o_cnt = cnt_q;
endmodule

// File: rtl/rpd_pipe_ctrl.sv
// Sequences the short/long moving-average fill phases and strobes the
// datapath once per accepted ECG sample. All outputs come straight from flops.
module rpd_pipe_ctrl
  import rpd_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int PIPE_LAT  = 1
) (
  input  logic                 i_clk,
  input  logic                 i_nrst,
  input  logic                 i_en,
  input  logic                 i_sample_valid,
  input  logic [CNT_WIDTH-1:0] i_short_len,
  input  logic [CNT_WIDTH-1:0] i_long_len,
  output logic                 o_ce,
  output logic                 o_ma_short_valid,
  output logic                 o_ma_long_valid,
  output logic                 o_busy,
  output logic                 o_cfg_err,
  output logic [1:0]           o_state,
  output logic [CNT_WIDTH-1:0] o_sample_cnt
);
  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] short_len_q, short_len_d, long_len_q, long_len_d;
  logic                 ce_q, ce_d, sv_q, sv_d, lv_q, lv_d;
  logic                 busy_q, busy_d, cfg_err_q, cfg_err_d;
  logic                 accept, cnt_clr, cfg_ok, hit_short, hit_long;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH:0]   cnt_inc;

  sat_counter #(.W(CNT_WIDTH)) u_cnt (
    .i_clk  (i_clk),
    .i_nrst (i_nrst),
    .i_en   (accept),
    .i_clr  (cnt_clr),
    .o_cnt  (cnt)
  );

  // Phase-end test looks at the count this acceptance produces, so the
  // valid level lands on the same edge as that sample's strobe.
  assign cnt_inc   = {1'b0, cnt} + {{CNT_WIDTH{1'b0}}, 1'b1};
  assign accept    = (state_q != IDLE) && i_en && i_sample_valid;
  assign hit_short = accept && (cnt_inc == {1'b0, short_len_q});
  assign hit_long  = accept && (cnt_inc == {1'b0, long_len_q});
  assign cfg_ok    = (i_short_len != '0) && (i_short_len <= i_long_len);

  always_comb begin
    state_d     = state_q;
    short_len_d = short_len_q;
    long_len_d  = long_len_q;
    sv_d        = sv_q;
    lv_d        = lv_q;
    cfg_err_d   = cfg_err_q;
    cnt_clr     = 1'b0;
    ce_d        = accept && (PIPE_LAT == 1);

    case (state_q)
      IDLE: begin
        if (cfg_err_q) begin
          cfg_err_d = i_en;
        end else if (i_en) begin
          if (cfg_ok) begin
            short_len_d = i_short_len;
            long_len_d  = i_long_len;
            cnt_clr     = 1'b1;
            state_d     = FILL_SHORT;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      FILL_SHORT: begin
        if (hit_short) begin
          sv_d = 1'b1;
          if (short_len_q == long_len_q) begin
            lv_d    = 1'b1;
            state_d = RUN;
          end else begin
            state_d = FILL_LONG;
          end
        end
      end
      FILL_LONG: begin
        if (hit_long) begin
          lv_d    = 1'b1;
          state_d = RUN;
        end
      end
      default: ;
    endcase

    // Disable aborts from any active state; a same-cycle strobe is dropped
    // because accept already requires i_en.
    if (state_q != IDLE && !i_en) begin
      state_d = IDLE;
      sv_d    = 1'b0;
      lv_d    = 1'b0;
      cnt_clr = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q     <= IDLE;
      short_len_q <= '0;
      long_len_q  <= '0;
      ce_q        <= 1'b0;
      sv_q        <= 1'b0;
      lv_q        <= 1'b0;
      busy_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      short_len_q <= short_len_d;
      long_len_q  <= long_len_d;
      ce_q        <= ce_d;
      sv_q        <= sv_d;
      lv_q        <= lv_d;
      busy_q      <= busy_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign o_ce             = ce_q;
  assign o_ma_short_valid = sv_q;
  assign o_ma_long_valid  = lv_q;
  assign o_busy           = busy_q;
  assign o_cfg_err        = cfg_err_q;
  assign o_state          = state_q;
  assign o_sample_cnt     = cnt;
endmodule

// File: tb/tb_rpd_pipe_ctrl.sv
// Scoreboard bench for rpd_pipe_ctrl: stimulus queues the expected status of
// each datapath strobe, a negedge monitor pops and compares on every o_ce.
module tb_rpd_pipe_ctrl;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          nrst, en, sval;
  logic [CW-1:0] short_len, long_len;
  logic          ce, sv, lv, busy, cfg_err;
  logic [1:0]    state;
  logic [CW-1:0] cnt;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int n = 0;
  int s_len = 0;
  int l_len = 0;

  typedef struct {
    int         cyc;
    logic [7:0] stat;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  rpd_pipe_ctrl #(.CNT_WIDTH(CW), .PIPE_LAT(1)) dut (
    .i_clk            (clk),
    .i_nrst           (nrst),
    .i_en             (en),
    .i_sample_valid   (sval),
    .i_short_len      (short_len),
    .i_long_len       (long_len),
    .o_ce             (ce),
    .o_ma_short_valid (sv),
    .o_ma_long_valid  (lv),
    .o_busy           (busy),
    .o_cfg_err        (cfg_err),
    .o_state          (state),
    .o_sample_cnt     (cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected {count, short valid, long valid, state} seen with the strobe of sample n.
  function automatic logic [7:0] model(input int k, input int s, input int l);
    logic [3:0] c;
    logic [1:0] st;
    c  = (k > 15) ? 4'd15 : 4'(k);
    st = (k < s) ? 2'd1 : ((k < l) ? 2'd2 : 2'd3);
    return {c, (k >= s), (k >= l), st};
  endfunction

  always @(negedge clk) begin
    if (ce === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL extra_ce: got strobe at cycle %0d, expected none", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("ce_cycle", cyc, mon_e.cyc);
        chk("ce_status", {24'd0, cnt, sv, lv, state}, {24'd0, mon_e.stat});
      end
    end
  end

  task automatic tick(input logic v);
    @(posedge clk); #1;
    sval = v;
    if (v) begin
      n++;
      sb.push_back('{cyc + 1, model(n, s_len, l_len)});
    end
  endtask

  task automatic start(input int s, input int l);
    @(posedge clk); #1;
    short_len = CW'(s); long_len = CW'(l); en = 1'b1;
    s_len = s; l_len = l; n = 0;
    @(posedge clk); #1;
    chk("start_state", {30'd0, state}, 32'd1);
    chk("start_busy", {31'd0, busy}, 32'd1);
    // Scramble the live lengths: only the latched copies may matter now.
    short_len = CW'(1); long_len = CW'(1);
  endtask

  task automatic chk_idle(input string nm);
    chk(nm, {21'd0, ce, sv, lv, busy, cfg_err, state, cnt}, 32'd0);
  endtask

  task automatic stop();
    @(posedge clk); #1;
    en = 1'b0; sval = 1'b0;
    @(posedge clk); #1;
    chk_idle("stop_idle");
  endtask

  initial begin
    nrst = 1'b0; en = 1'b0; sval = 1'b0; short_len = '0; long_len = '0;
    #1;
    chk_idle("reset_outs");
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;

    // Normal fill, samples every cycle.
    start(4, 8);
    repeat (10) tick(1'b1);
    repeat (2) tick(1'b0);
    chk("fill_run", {30'd0, state}, 32'd3);
    stop();

    // Sparse strobes every 5th cycle.
    start(2, 3);
    for (int k = 0; k < 4; k++) begin
      tick(1'b1);
      repeat (4) tick(1'b0);
    end
    chk("sparse_run", {30'd0, state}, 32'd3);
    stop();

    // Rejected configurations: short > long, then short = 0.
    @(posedge clk); #1;
    short_len = 4'd5; long_len = 4'd3; en = 1'b1;
    @(posedge clk); #1;
    chk("bad_err", {31'd0, cfg_err}, 32'd1);
    chk("bad_busy", {31'd0, busy}, 32'd0);
    chk("bad_state", {30'd0, state}, 32'd0);
    @(posedge clk); #1;
    chk("bad_err_hold", {31'd0, cfg_err}, 32'd1);
    en = 1'b0;
    @(posedge clk); #1;
    chk("bad_err_clr", {31'd0, cfg_err}, 32'd0);
    short_len = 4'd0; long_len = 4'd3; en = 1'b1;
    @(posedge clk); #1;
    chk("zero_err", {31'd0, cfg_err}, 32'd1);
    en = 1'b0;
    @(posedge clk); #1;
    chk_idle("zero_clr");

    // Equal lengths go straight from FILL_SHORT to RUN.
    start(6, 6);
    repeat (6) tick(1'b1);
    repeat (2) tick(1'b0);
    chk("equal_run", {30'd0, state}, 32'd3);
    stop();

    // Abort on the 3rd FILL_LONG strobe: that strobe must produce no o_ce.
    start(2, 6);
    repeat (4) tick(1'b1);
    @(posedge clk); #1;
    sval = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    sval = 1'b0;
    chk_idle("abort_idle");
    repeat (2) tick(1'b0);

    // Asynchronous reset mid-RUN; block must stay idle without a new enable.
    start(1, 2);
    repeat (3) tick(1'b1);
    repeat (2) tick(1'b0);
    chk("pre_rst_run", {30'd0, state}, 32'd3);
    #2 nrst = 1'b0; en = 1'b0;
    #1 chk_idle("async_rst");
    chk("rst_sb_drain", sb.size(), 32'd0);
    @(posedge clk); #1 nrst = 1'b1;
    @(posedge clk); #1;
    chk_idle("post_rst_idle");

    // Saturation of the 4-bit sample counter.
    start(3, 5);
    repeat (20) tick(1'b1);
    repeat (2) tick(1'b0);
    chk("sat_cnt", {28'd0, cnt}, 32'd15);
    chk("sat_state", {30'd0, state}, 32'd3);
    stop();

    repeat (2) @(posedge clk);
    #1 chk("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
